// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the grant arbiter slice.
package arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/highest_pick8.sv
// Combinational highest-set-bit picker: one-hot winner, its index, and an any flag.
module highest_pick8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_cand,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);
    logic [NUM_REQ-1:0] w_higher;

    // w_higher[gi] is set when any candidate above bit gi is present.
    assign w_higher[NUM_REQ-1] = 1'b0;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ - 1; gi++) begin : g_higher
            assign w_higher[gi] = |i_cand[NUM_REQ-1:gi+1];
        end
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign o_onehot[gi] = i_cand[gi] & ~w_higher[gi];
        end
    endgenerate

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_onehot[i]) o_idx = IDX_W'(i);
        end
    end

    assign o_any = |i_cand;
endmodule

// File: rtl/grant_arbiter8.sv
// Non-preemptive 8-way fixed-priority arbiter (bit 7 highest) with a hold-time
// limit that forcibly releases an owner after HOLD_MAX consecutive cycles.
module grant_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic               r_gnt_valid;
    logic               r_timeout;
    logic [7:0]         r_hold_cnt;

    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_any;
    logic               w_owner_req;
    logic               w_expired;

    // In GRANT the owner is excluded so a release or timeout hands off to someone else.
    assign w_cand      = (r_state == ST_IDLE) ? req : (req & ~r_gnt);
    assign w_owner_req = |(req & r_gnt);
    assign w_expired   = (r_hold_cnt == HOLD_LAST);

    highest_pick8 u_pick (
        .i_cand   (w_cand),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_any    (w_win_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_hold_cnt <= '0;
                    if (w_win_any) begin
                        r_state     <= ST_GRANT;
                        r_gnt       <= w_win_onehot;
                        r_gnt_idx   <= w_win_idx;
                        r_gnt_valid <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req || w_expired) begin
                        // An owner dropping on its last allowed cycle is a plain release.
                        r_timeout  <= w_owner_req;
                        r_hold_cnt <= '0;
                        if (w_win_any) begin
                            r_gnt       <= w_win_onehot;
                            r_gnt_idx   <= w_win_idx;
                            r_gnt_valid <= 1'b1;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_gnt       <= '0;
                            r_gnt_idx   <= '0;
                            r_gnt_valid <= 1'b0;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= '0;
                    r_gnt_idx   <= '0;
                    r_gnt_valid <= 1'b0;
                    r_hold_cnt  <= '0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;
endmodule

// File: tb/tb_grant_arbiter8.sv
// Directed bench for grant_arbiter8 with HOLD_MAX = 4; observed word is {gnt, gnt_idx, gnt_valid, timeout}.
module tb_grant_arbiter8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;
    logic [12:0] w_obs;
    logic [12:0] exp_v;

    assign w_obs = {gnt, gnt_idx, gnt_valid, timeout};

    grant_arbiter8 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        exp_v = {8'h00, 3'd0, 1'b0, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL reset_hold: got %h exp %h", w_obs, exp_v); end
        else $display("reset_hold req=%h obs=%h", req, w_obs);
        tick(); rst = 1'b0;
        tick();
        exp_v = {8'h00, 3'd0, 1'b0, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL reset_idle: got %h exp %h", w_obs, exp_v); end
        else $display("reset_idle req=%h obs=%h", req, w_obs);
        req = 8'h10; tick(); tick();
        exp_v = {8'h10, 3'd4, 1'b1, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL pre_reset_grant: got %h exp %h", w_obs, exp_v); end
        else $display("pre_reset_grant req=%h obs=%h", req, w_obs);
        #2 rst = 1'b1; #1;
        exp_v = {8'h00, 3'd0, 1'b0, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL async_reset: got %h exp %h", w_obs, exp_v); end
        else $display("async_reset req=%h obs=%h", req, w_obs);
        tick(); rst = 1'b0;
        tick();
        exp_v = {8'h10, 3'd4, 1'b1, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL post_reset_grant: got %h exp %h", w_obs, exp_v); end
        else $display("post_reset_grant req=%h obs=%h", req, w_obs);
        req = 8'h00; tick();
    endtask

    task automatic test_nonpreempt();
        req = 8'h05; tick();
        exp_v = {8'h04, 3'd2, 1'b1, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL np_first: got %h exp %h", w_obs, exp_v); end
        else $display("np_first req=%h obs=%h", req, w_obs);
        req = 8'h85; tick();
        n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL np_no_preempt: got %h exp %h", w_obs, exp_v); end
        else $display("np_no_preempt req=%h obs=%h", req, w_obs);
        req = 8'h81; tick();
        exp_v = {8'h80, 3'd7, 1'b1, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL np_handoff: got %h exp %h", w_obs, exp_v); end
        else $display("np_handoff req=%h obs=%h", req, w_obs);
        req = 8'h01; tick();
        exp_v = {8'h01, 3'd0, 1'b1, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL np_low: got %h exp %h", w_obs, exp_v); end
        else $display("np_low req=%h obs=%h", req, w_obs);
        req = 8'h00; tick();
    endtask

    task automatic test_timeout_comp();
        req = 8'h81;
        for (int c = 0; c < 4; c++) begin
            tick();
            exp_v = {8'h80, 3'd7, 1'b1, 1'b0}; n_cmp++;
            if (w_obs !== exp_v) begin n_err++; $display("FAIL to_hold[%0d]: got %h exp %h", c, w_obs, exp_v); end
            else $display("to_hold[%0d] req=%h obs=%h", c, req, w_obs);
        end
        tick();
        exp_v = {8'h01, 3'd0, 1'b1, 1'b1}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL to_switch: got %h exp %h", w_obs, exp_v); end
        else $display("to_switch req=%h obs=%h", req, w_obs);
        tick();
        exp_v = {8'h01, 3'd0, 1'b1, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL to_pulse_end: got %h exp %h", w_obs, exp_v); end
        else $display("to_pulse_end req=%h obs=%h", req, w_obs);
        req = 8'h00; tick();
        exp_v = {8'h00, 3'd0, 1'b0, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL to_idle: got %h exp %h", w_obs, exp_v); end
        else $display("to_idle req=%h obs=%h", req, w_obs);
    endtask

    task automatic test_timeout_sole();
        req = 8'h08;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                exp_v = {8'h08, 3'd3, 1'b1, 1'b0}; n_cmp++;
                if (w_obs !== exp_v) begin n_err++; $display("FAIL sole_hold[%0d.%0d]: got %h exp %h", r, c, w_obs, exp_v); end
                else $display("sole_hold[%0d.%0d] req=%h obs=%h", r, c, req, w_obs);
            end
            tick();
            exp_v = {8'h00, 3'd0, 1'b0, 1'b1}; n_cmp++;
            if (w_obs !== exp_v) begin n_err++; $display("FAIL sole_gap[%0d]: got %h exp %h", r, w_obs, exp_v); end
            else $display("sole_gap[%0d] req=%h obs=%h", r, req, w_obs);
        end
        req = 8'h00; tick();
        exp_v = {8'h00, 3'd0, 1'b0, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL sole_idle: got %h exp %h", w_obs, exp_v); end
        else $display("sole_idle req=%h obs=%h", req, w_obs);
    endtask

    task automatic test_back_to_back();
        req = 8'h06; tick();
        exp_v = {8'h04, 3'd2, 1'b1, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL b2b_first: got %h exp %h", w_obs, exp_v); end
        else $display("b2b_first req=%h obs=%h", req, w_obs);
        req = 8'h02; tick();
        exp_v = {8'h02, 3'd1, 1'b1, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL b2b_second: got %h exp %h", w_obs, exp_v); end
        else $display("b2b_second req=%h obs=%h", req, w_obs);
        req = 8'h00; tick();
        exp_v = {8'h00, 3'd0, 1'b0, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL b2b_idle: got %h exp %h", w_obs, exp_v); end
        else $display("b2b_idle req=%h obs=%h", req, w_obs);
    endtask

    task automatic test_simul_release();
        req = 8'h21;
        for (int c = 0; c < 4; c++) tick();
        exp_v = {8'h20, 3'd5, 1'b1, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL sim_last_cycle: got %h exp %h", w_obs, exp_v); end
        else $display("sim_last_cycle req=%h obs=%h", req, w_obs);
        req = 8'h01; tick();
        exp_v = {8'h01, 3'd0, 1'b1, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL sim_release: got %h exp %h", w_obs, exp_v); end
        else $display("sim_release req=%h obs=%h", req, w_obs);
        req = 8'h00; tick();
        exp_v = {8'h00, 3'd0, 1'b0, 1'b0}; n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL sim_idle: got %h exp %h", w_obs, exp_v); end
        else $display("sim_idle req=%h obs=%h", req, w_obs);
    endtask

    initial begin
        test_reset();
        test_nonpreempt();
        test_timeout_comp();
        test_timeout_sole();
        test_back_to_back();
        test_simul_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/grant_arbiter8.md
# grant_arbiter8

Registered 8-requester arbiter that shares one resource among requesters `req[7:0]`. Bit 7 has the highest priority, matching the priority-to-onehot convention of the encoder datapath. It issues a held one-hot grant plus a 3-bit grant index. A hold-time limit keeps a high-priority owner from starving lower requesters. It sits in front of the shared encoder/decoder datapath and drives its select and enable inputs.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive cycles one owner may hold the grant; legal range 2..255.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  8  request vector; `req[i]` is held high while requester i wants or uses the resource.
- `gnt`  output  8  registered one-hot grant, or all zero.
- `gnt_idx`  output  3  binary index of the set `gnt` bit; 0 when `gnt` = 0.
- `gnt_valid`  output  1  OR of `gnt`.
- `timeout`  output  1  one-cycle pulse; the previous owner was forcibly released this cycle.

## Operation
- **States:**
  - IDLE: `gnt` = 0.
  - GRANT: exactly one `gnt` bit set; the granted requester is the owner.
- **Winner selection:** the highest set bit of the candidate vector `cand`.
  - In IDLE: `cand = req`.
  - At normal release: `cand = req & ~owner`.
  - At timeout: `cand = req & ~owner`.
- **IDLE:**
  - If `req != 0`: register the winner's one-hot into `gnt` and its index into `gnt_idx`; clear `hold_cnt`; go to GRANT.
  - Else: stay in IDLE.
- **GRANT, normal release** (`req[owner]` = 0):
  - If `cand != 0`: grant the new winner next cycle (back-to-back, no dead cycle); clear `hold_cnt`.
  - Else: go to IDLE with `gnt` = 0.
- **GRANT, timeout** (`req[owner]` = 1 and `hold_cnt` = `HOLD_MAX-1`):
  - Forced release; `timeout` = 1 on the next cycle.
  - If `cand != 0`: grant its winner.
  - Else: go to IDLE for one cycle, then re-arbitrate normally. The old owner may then win again.
- **GRANT, otherwise:** hold `gnt`; increment `hold_cnt`.
- **Priority inside GRANT:** a higher-priority request arriving does not preempt the owner (non-preemptive). It wins at the next release or timeout.
- **Counter:** `hold_cnt` is 8 bits. It saturates logically at `HOLD_MAX-1` and never wraps while owned.
- **Reset:** `rst` high at any time, including mid-grant, immediately forces:
  - IDLE, `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0, `hold_cnt` = 0.
- **Reset release:** the first arbitration happens on the first rising edge with `rst` low.

## Timing
- Latency from `req` rising in IDLE to `gnt`: 1 cycle, all outputs registered.
- Release latency: `req[owner]` low at edge k gives the new `gnt` value visible after edge k.
- A single owner's grant is high for at most `HOLD_MAX` consecutive cycles.
- `timeout` is asserted in the same cycle as the post-release `gnt` value and lasts exactly 1 cycle.
- **Simultaneous events:**
  - Owner drops `req` on the timeout cycle: treated as a normal release; `timeout` = 0.
  - New requests arriving on the release cycle: they take part in that arbitration.
- `gnt_idx` and `gnt_valid` always change on the same edge as `gnt`.

## Structure
- **Shared package `arb_pkg`:**
  - `NUM_REQ` = 8, `IDX_W` = 3.
  - State encoding `ST_IDLE` = 1'b0, `ST_GRANT` = 1'b1.
- **Sub-module `highest_pick8`:** combinational; 8-bit candidate in, one-hot out, plus 3-bit index and any flag.
  - Instantiated once, fed by a mux of `req` and `req & ~owner`.
- **Top level:** state register, owner/`gnt` register, `hold_cnt`, `timeout` flop.

## Test plan
- **Reset mid-grant:** `req` = 8'h10, grant held, assert `rst` asynchronously between edges -> `gnt` = 0, `gnt_idx` = 0, `timeout` = 0 immediately; after release with `req` = 8'h10, `gnt` = 8'h10 one edge later.
- **Non-preemptive priority:** `req` = 8'h05 -> `gnt` = 8'h04, `gnt_idx` = 2. Raise `req[7]` -> `gnt` stays 8'h04. Drop `req[2]` -> next cycle `gnt` = 8'h80, `gnt_idx` = 7; later `req` = 8'h01 gives `gnt` = 8'h01.
- **Timeout with competitor:** `HOLD_MAX` = 4, hold `req` = 8'h81 -> `gnt` = 8'h80 for exactly 4 cycles, then `gnt` = 8'h01 with `timeout` = 1 for one cycle.
- **Timeout, sole requester:** `req` = 8'h08 constant, `HOLD_MAX` = 4 -> 4 cycles granted, then 1 cycle of `gnt` = 0 with `timeout` = 1, then `gnt` = 8'h08 again; pattern repeats.
- **Back-to-back release:** `req` = 8'h06, drop `req[2]` -> `gnt` goes 8'h04 -> 8'h02 with no zero cycle; drop `req[1]` -> `gnt` = 0, `gnt_valid` = 0.
- **Simultaneous release and timeout:** owner drops `req` on the `hold_cnt` = `HOLD_MAX-1` cycle -> `timeout` stays 0 and the next winner is granted normally.
